ram_port_master: RTL

RAM_PORT_MASTER -- requirements
Module: ram_port_master

---
 rtl/mr_ram_pkg.sv | 30 +++
 rtl/ram_port_master_if.sv | 46 ++++
 rtl/ram_rsp_fifo.sv | 56 +++++
 rtl/ram_port_master.sv | 63 ++++++
 4 files changed

// File: rtl/mr_ram_pkg.sv
// Shared width derivations for the RAM port master slice.
// Purpose : one place to turn L2WIDTH / L2SIZE into data, address and strobe widths.
// Contents: default parameter values, width helper functions, default-width localparams.
package mr_ram_pkg;

    localparam int unsigned DefL2Width  = 3;
    localparam int unsigned DefL2Size   = 14;
    localparam int unsigned DefRspDepth = 4;

    // Data bits per word: 8 bits per byte, 2**l2width bytes.
    function automatic int unsigned data_width(input int unsigned l2width);
        return 8 << l2width;
    endfunction

    // Word address bits: byte address bits minus the byte-in-word bits.
    function automatic int unsigned addr_width(input int unsigned l2width,
                                               input int unsigned l2size);
        return l2size - l2width;
    endfunction

    // One strobe per data byte.
    function automatic int unsigned strb_width(input int unsigned l2width);
        return 1 << l2width;
    endfunction

    localparam int unsigned DefDataW = data_width(DefL2Width);
    localparam int unsigned DefAddrW = addr_width(DefL2Width, DefL2Size);
    localparam int unsigned DefStrbW = strb_width(DefL2Width);

endpackage

// File: rtl/ram_port_master_if.sv
// Bus bundle between a requester, the RAM port master and one dp_ram port.
// Signals : req_* (request channel), rsp_* (read response channel),
//           ram_* (dp_ram port drive and read data).
// Modports: master = the port master itself, slave = requester/consumer/RAM side.
interface ram_port_master_if
    import mr_ram_pkg::*;
#(
    parameter int unsigned L2WIDTH = DefL2Width,
    parameter int unsigned L2SIZE  = DefL2Size
) ();

    localparam int unsigned DataW = data_width(L2WIDTH);
    localparam int unsigned AddrW = addr_width(L2WIDTH, L2SIZE);
    localparam int unsigned StrbW = strb_width(L2WIDTH);

    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AddrW-1:0] req_addr;
    logic [DataW-1:0] req_wdata;
    logic [StrbW-1:0] req_bwe;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [DataW-1:0] rsp_data;

    logic             ram_enable;
    logic [AddrW-1:0] ram_addr;
    logic [DataW-1:0] ram_wr_data;
    logic             ram_WE;
    logic [StrbW-1:0] ram_BWE;
    logic [DataW-1:0] ram_rd_data;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_bwe, rsp_ready, ram_rd_data,
        output req_ready, rsp_valid, rsp_data,
        output ram_enable, ram_addr, ram_wr_data, ram_WE, ram_BWE
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_bwe, rsp_ready, ram_rd_data,
        input  req_ready, rsp_valid, rsp_data,
        input  ram_enable, ram_addr, ram_wr_data, ram_WE, ram_BWE
    );

endinterface

// File: rtl/ram_rsp_fifo.sv
// Read response buffer for the RAM port master.
// Ports: clk, reset (async active-high), i_push/i_data (write side),
//        i_pop/o_data (read side, o_data is the head), o_count (entries held).
// Storage is not reset; only pointers and count are, so the head is don't-care when empty.
module ram_rsp_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic [CntW-1:0]  o_count
);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;

    // Depth is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(i_pop && (r_count == '0)));
            assert (!(i_push && (r_count == CntW'(Depth))));
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ram_port_master.sv
// Drives one dp_ram port from a valid/ready request channel and returns read data
// in request order through a small response FIFO.
// Ports: clk, reset (async active-high), bus (ram_port_master_if.master: request,
//        response and dp_ram port signals).
// Flow control reserves a FIFO slot for every read still in flight, so the FIFO can
// never overflow regardless of rsp_ready.
module ram_port_master
    import mr_ram_pkg::*;
#(
    parameter int unsigned L2WIDTH   = DefL2Width,
    parameter int unsigned L2SIZE    = DefL2Size,
    parameter int unsigned RSP_DEPTH = DefRspDepth
) (
    input  logic               clk,
    input  logic               reset,
    ram_port_master_if.master  bus
);

    localparam int unsigned DataW = data_width(L2WIDTH);
    localparam int unsigned CntW  = $clog2(RSP_DEPTH) + 1;

    logic            r_inflight;
    logic            w_accept;
    logic            w_pop;
    logic [CntW-1:0] w_count;
    logic [CntW:0]   w_occupancy;

    assign w_occupancy = {1'b0, w_count} + (CntW + 1)'(r_inflight);
    assign bus.req_ready = !reset && (w_occupancy < (CntW + 1)'(RSP_DEPTH));
    assign w_accept = bus.req_valid && bus.req_ready;

    assign bus.ram_enable  = w_accept;
    assign bus.ram_addr    = bus.req_addr;
    assign bus.ram_wr_data = bus.req_wdata;
    assign bus.ram_WE      = bus.req_we;
    assign bus.ram_BWE     = bus.req_bwe;

    // Marks the cycle in which ram_rd_data carries the result of an accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept && !bus.req_we;
        end
    end

    assign bus.rsp_valid = (w_count != '0);
    assign w_pop = bus.rsp_valid && bus.rsp_ready;

    ram_rsp_fifo #(
        .Depth (RSP_DEPTH),
        .Width (DataW)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_data  (bus.ram_rd_data),
        .i_pop   (w_pop),
        .o_data  (bus.rsp_data),
        .o_count (w_count)
    );

endmodule
